div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
Parameters: none.
REQ-001 SHALL have these ports:
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester divide request; bit 0 is the CPU pipeline, bit 1 is the coprocessor.
- req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] and req_ready[i] are both high on a posedge.
- req_signed  in  2  per-requester op select: 1 for signed (div), 0 for unsigned (divu).
- req_dividend0 / req_dividend1  in  32 each  per-requester dividend.
- req_divisor0 / req_divisor1  in  32 each  per-requester divisor.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when rsp_valid and rsp_ready are both high on a posedge.
- rsp_id  out  1  requester that owns the result.
- rsp_quotient  out  32  result quotient.
- rsp_remainder  out  32  result remainder.
- div_op_div  out  1  one-cycle start pulse for a signed divide, to the shared divider.
- div_op_divu  out  1  one-cycle start pulse for an unsigned divide, to the shared divider.
- div_dividend  out  32  operand to the divider.
- div_divisor  out  32  operand to the divider.
- div_quotient  in  32  divider result.
- div_remainder  in  32  divider result.
- div_stall  in  1  divider busy; high for 32 cycles starting the cycle after a start pulse, valid result on the first low cycle.

Function
REQ-002 SHALL implement a four-state FSM: IDLE, ISSUE, BUSY, DONE.
REQ-003 IDLE: when any req_valid is high, SHALL grant exactly one requester, assert only its req_ready that cycle, latch its operands, op type and id on the accepting edge, then go to ISSUE.
REQ-004 Arbitration SHALL be round-robin:
- When both requesters are valid, grant the one not granted last.
- A last-grant pointer updates on each accept.
- After reset the pointer favours requester 0.
REQ-005 req_ready SHALL be low in every state other than IDLE.
REQ-006 ISSUE: SHALL drive div_op_div (signed) or div_op_divu (unsigned) high for exactly one cycle with the latched operands on div_dividend/div_divisor, then go to BUSY.
REQ-007 div_op_div and div_op_divu SHALL never be high together, and SHALL never be high outside ISSUE.
REQ-008 div_dividend and div_divisor SHALL hold the latched operands from ISSUE through BUSY.
REQ-009 BUSY: on the first cycle with div_stall low, SHALL register div_quotient, div_remainder and the id into rsp_* and go to DONE.
REQ-010 DONE: rsp_valid SHALL be high.
- rsp_quotient, rsp_remainder and rsp_id SHALL stay stable until accepted.
- On acceptance SHALL go to IDLE; the new grant happens in the following IDLE cycle, never in DONE.
REQ-011 rsp_valid SHALL be low in all states except DONE.
REQ-012 Latency SHALL be as follows:
- Accept on the edge ending cycle T: start pulse in T+1, div_stall high T+2..T+33, capture on the edge ending T+34, rsp_valid from T+35.
- rsp_ready low holds DONE indefinitely with no change to any rsp_* output.
REQ-013 A requester dropping req_valid while not granted SHALL be allowed; no request SHALL be lost or duplicated once accepted.
REQ-014 Simultaneous req_valid on both bits in the same cycle as DONE acceptance: arbitration SHALL occur only in the next IDLE cycle and SHALL follow REQ-004.

Reset
REQ-015 On reset the block SHALL:
- enter IDLE;
- clear req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, div_op_div, div_op_divu, div_dividend and div_divisor to 0;
- point the last-grant pointer so requester 0 wins.
REQ-016 Reset in ISSUE, BUSY or DONE SHALL discard the in-flight operation and any pending result.
- Reset drives the divider's reset, so no divider abort pulse is needed.

Configuration
REQ-017 With DIV_ARB_DIV0_FAST_EN defined, a latched divisor of 0 SHALL bypass the divider:
- ISSUE goes straight to DONE with no start pulse, rsp_valid from T+2, rsp_remainder = dividend.
- Unsigned: rsp_quotient = 0xFFFFFFFF.
- Signed: rsp_quotient = 0xFFFFFFFF if dividend[31] = 0, else 0x00000001.
REQ-018 Without DIV_ARB_DIV0_FAST_EN, a zero divisor SHALL be issued to the divider like any other operand, with the REQ-012 timing, and whatever the divider returns SHALL be passed through.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Single request: req0 unsigned 100/7, rsp_ready held high -> div_op_divu pulse at T+1, rsp_valid at T+35, quotient 14, remainder 2, rsp_id 0.
- Signed: req1 signed -100/7 -> div_op_div pulse, quotient 0xFFFFFFF2 (-14), remainder 2 (the divider's magnitude remainder), rsp_id 1.
- Fairness: both requesters held valid for 4 operations -> grants in the order 0,1,0,1, with no req_ready while non-IDLE.
- Backpressure: rsp_ready low for 10 cycles in DONE -> rsp_* stable, no new grant, IDLE on the cycle after acceptance.
- Mid-operation reset: reset asserted at T+10 of a divide -> next cycle all outputs 0, IDLE, next grant goes to requester 0.
- Divide by zero with the macro defined: unsigned 5/0 -> no start pulse, rsp_valid at T+2, quotient 0xFFFFFFFF, remainder 5.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one iterative divider between the CPU (0) and the coprocessor (1).
// Optional feature DIV_ARB_DIV0_FAST_EN: a zero divisor is answered locally without starting the divider.
module div_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_signed,
    input  logic [31:0] req_dividend0,
    input  logic [31:0] req_dividend1,
    input  logic [31:0] req_divisor0,
    input  logic [31:0] req_divisor1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_quotient,
    output logic [31:0] rsp_remainder,
    output logic        div_op_div,
    output logic        div_op_divu,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_stall
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant_id;
    logic        accept;
    logic        op_signed;
    logic        op_id;
    logic [31:0] op_dividend;
    logic [31:0] op_divisor;
    logic        div0_fast;

    // last_grant holds the previously granted requester; on a tie the other one wins
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (req_valid != 2'b00) && !reset;
    assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

`ifdef DIV_ARB_DIV0_FAST_EN
    logic [31:0] fast_quotient;
    assign div0_fast     = (op_divisor == 32'd0);
    assign fast_quotient = (op_signed && op_dividend[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`else
    assign div0_fast = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        div_op_div  = 1'b0;
        div_op_divu = 1'b0;
        rsp_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid != 2'b00) state_next = ISSUE;
            end
            ISSUE: begin
                if (div0_fast) begin
                    state_next = DONE;
                end else begin
                    div_op_div  = op_signed;
                    div_op_divu = !op_signed;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (!div_stall) state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_signed     <= 1'b0;
            op_id         <= 1'b0;
            op_dividend   <= 32'd0;
            op_divisor    <= 32'd0;
            rsp_id        <= 1'b0;
            rsp_quotient  <= 32'd0;
            rsp_remainder <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant  <= grant_id;
                op_id       <= grant_id;
                op_signed   <= req_signed[grant_id];
                op_dividend <= grant_id ? req_dividend1 : req_dividend0;
                op_divisor  <= grant_id ? req_divisor1 : req_divisor0;
            end
            if (state == BUSY && !div_stall) begin
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
                rsp_id        <= op_id;
            end
`ifdef DIV_ARB_DIV0_FAST_EN
            // dividing by zero resolves here; the remainder is the dividend itself
            if (state == ISSUE && div0_fast) begin
                rsp_quotient  <= fast_quotient;
                rsp_remainder <= op_dividend;
                rsp_id        <= op_id;
            end
`endif
        end
    end

    assign div_dividend = op_dividend;
    assign div_divisor  = op_divisor;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed bench for div_arbiter with a behavioural divider and a transaction-level reference.
// Follows DIV_ARB_DIV0_FAST_EN the same way the design does.
module tb_div_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_signed;
    logic [31:0] req_dividend0, req_dividend1, req_divisor0, req_divisor1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic        div_op_div, div_op_divu;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic        div_stall;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    div_arbiter dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_dividend0(req_dividend0), .req_dividend1(req_dividend1),
        .req_divisor0(req_divisor0), .req_divisor1(req_divisor1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .div_op_div(div_op_div), .div_op_divu(div_op_divu),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_stall(div_stall)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Divider result: truncating quotient, magnitude remainder; x/0 gives all-ones and the dividend
    function automatic logic [63:0] ref_divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        return {(a[31] ^ b[31]) ? -q : q, ma % mb};
    endfunction

    function automatic logic [63:0] expected_result(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ARB_DIV0_FAST_EN
        if (b == 32'd0) return {(sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF, a};
`endif
        return ref_divide(sgn, a, b);
    endfunction

    // Shared divider stand-in: 32 stall cycles, garbage on the result bus while stalled
    int          stall_cnt;
    logic [31:0] dm_q, dm_r;
    always @(posedge clock) begin
        if (reset) begin
            stall_cnt <= 0;
        end else if (div_op_div || div_op_divu) begin
            stall_cnt    <= 32;
            {dm_q, dm_r} <= ref_divide(div_op_div, div_dividend, div_divisor);
        end else if (stall_cnt > 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end
    assign div_stall     = (stall_cnt != 0);
    assign div_quotient  = div_stall ? 32'hDEAD_BEEF : dm_q;
    assign div_remainder = div_stall ? 32'hBAAD_F00D : dm_r;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: one transaction in flight, timed from its accept cycle
    bit          model_on = 0, post_reset = 0, m_busy = 0, m_last = 1;
    bit          m_fast, m_sgn, m_id;
    int          m_acc;
    logic [31:0] m_dd, m_dv;
    logic [63:0] m_res;

    always @(negedge clock) begin
        int age;
        bit exp_v, g;
        logic [1:0] exp_rdy;
        exp_v   = 0;
        exp_rdy = 2'b00;
        if (req_valid == 2'b11) g = ~m_last;
        else g = req_valid[1];
        if (model_on && reset) begin
            check_output("ready_in_reset", req_ready, 0);
        end else if (model_on) begin
            if (post_reset) begin
                check_output("rst_rsp_id", rsp_id, 0);
                check_output("rst_quotient", rsp_quotient, 0);
                check_output("rst_remainder", rsp_remainder, 0);
                check_output("rst_dividend", div_dividend, 0);
                check_output("rst_divisor", div_divisor, 0);
            end
            if (!m_busy) begin
                if (req_valid != 2'b00) exp_rdy = g ? 2'b10 : 2'b01;
                check_output("req_ready_idle", req_ready, exp_rdy);
                check_output("rsp_valid_idle", rsp_valid, 0);
                check_output("div_op_idle", {div_op_div, div_op_divu}, 0);
            end else begin
                age   = cyc - m_acc;
                exp_v = m_fast ? (age >= 2) : (age >= 35);
                check_output("req_ready_busy", req_ready, 0);
                check_output("div_op_div", div_op_div, (age == 1 && !m_fast && m_sgn));
                check_output("div_op_divu", div_op_divu, (age == 1 && !m_fast && !m_sgn));
                if (age <= (m_fast ? 1 : 34)) begin
                    check_output("div_dividend", div_dividend, m_dd);
                    check_output("div_divisor", div_divisor, m_dv);
                end
                check_output("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    check_output("rsp_quotient", rsp_quotient, m_res[63:32]);
                    check_output("rsp_remainder", rsp_remainder, m_res[31:0]);
                    check_output("rsp_id", rsp_id, m_id);
                end
            end
        end
        if (reset) begin
            model_on   = 1;
            post_reset = 1;
            m_busy     = 0;
            m_last     = 1;
        end else if (model_on) begin
            post_reset = 0;
            if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    m_busy = 1;
                    m_acc  = cyc;
                    m_id   = g;
                    m_last = g;
                    m_sgn  = req_signed[g];
                    m_dd   = g ? req_dividend1 : req_dividend0;
                    m_dv   = g ? req_divisor1 : req_divisor0;
                    m_res  = expected_result(m_sgn, m_dd, m_dv);
`ifdef DIV_ARB_DIV0_FAST_EN
                    m_fast = (m_dv == 32'd0);
`else
                    m_fast = 0;
`endif
                end
            end else if (exp_v && rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] v, input logic [1:0] s, input logic [31:0] d0,
                                  input logic [31:0] v0, input logic [31:0] d1, input logic [31:0] v1, input logic rr);
        req_valid     = v;
        req_signed    = s;
        req_dividend0 = d0;
        req_divisor0  = v0;
        req_dividend1 = d1;
        req_divisor1  = v1;
        rsp_ready     = rr;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset     = 1'b1;
        req_valid = 2'b00;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic wait_accept(input bit id, output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (req_ready[id]) begin
                ok = 1;
                t  = cyc;
            end
        end
        check_output("accept_seen", ok, 1);
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clock);
        end
        check_output("rsp_seen", seen, 1);
    endtask

    task automatic drain();
        bit seen;
        rsp_ready = 1'b1;
        @(negedge clock);
        wait_rsp(seen);
        @(posedge clock); #1;
    endtask

    task automatic run_one(input bit id, input bit sgn, input logic [31:0] dd, input logic [31:0] dv,
                           input logic [31:0] eq, input logic [31:0] er, input int lat);
        int t;
        bit seen;
        apply_stimulus(id ? 2'b10 : 2'b01, {sgn, sgn}, dd, dv, dd, dv, 1'b1);
        wait_accept(id, t);
        @(posedge clock); #1;
        req_valid = 2'b00;
        @(negedge clock);
        check_output("start_pulse", sgn ? div_op_div : div_op_divu, (lat == 35) ? 1 : 0);
        wait_rsp(seen);
        check_output("latency", cyc - t, lat);
        check_output("lit_quotient", rsp_quotient, eq);
        check_output("lit_remainder", rsp_remainder, er);
        check_output("lit_id", rsp_id, id);
        @(posedge clock); #1;
    endtask

    initial begin
        int t;
        bit seen;
        bit grants [4];
        int n;
        apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] directed single requests");
        run_one(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 35);
        run_one(1, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'd2, 35);

        $display("[TB] fairness");
        pulse_reset();
        apply_stimulus(2'b11, 2'b00, 32'd40, 32'd3, 32'd41, 32'd4, 1'b1);
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clock);
            if (req_ready != 2'b00) begin
                grants[n] = req_ready[1];
                n++;
            end
        end
        @(posedge clock); #1;
        req_valid = 2'b00;
        check_output("fair_count", n, 4);
        check_output("fair_grant0", grants[0], 0);
        check_output("fair_grant1", grants[1], 1);
        check_output("fair_grant2", grants[2], 0);
        check_output("fair_grant3", grants[3], 1);
        drain();

        $display("[TB] backpressure");
        apply_stimulus(2'b01, 2'b00, 32'd1000, 32'd10, 32'd0, 32'd1, 1'b0);
        wait_accept(0, t);
        @(posedge clock); #1;
        req_valid = 2'b00;
        @(negedge clock);
        wait_rsp(seen);
        @(posedge clock); #1;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_output("bp_valid", rsp_valid, 1);
            check_output("bp_quotient", rsp_quotient, 32'd100);
            check_output("bp_remainder", rsp_remainder, 32'd0);
            check_output("bp_no_grant", req_ready, 2'b00);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_output("bp_grant_after", req_ready, 2'b10);
        @(posedge clock); #1;
        req_valid = 2'b00;
        drain();

        $display("[TB] mid-operation reset");
        apply_stimulus(2'b01, 2'b00, 32'd100, 32'd3, 32'd0, 32'd1, 1'b1);
        wait_accept(0, t);
        repeat (9) @(negedge clock);
        @(posedge clock); #1;
        reset     = 1'b1;
        req_valid = 2'b00;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_output("mr_rsp_valid", rsp_valid, 0);
        check_output("mr_ops", {div_op_div, div_op_divu}, 0);
        check_output("mr_quotient", rsp_quotient, 0);
        check_output("mr_dividend", div_dividend, 0);
        @(posedge clock); #1;
        req_valid = 2'b11;
        @(negedge clock);
        check_output("mr_grant0", req_ready, 2'b01);
        @(posedge clock); #1;
        req_valid = 2'b00;
        drain();

        $display("[TB] divide by zero");
`ifdef DIV_ARB_DIV0_FAST_EN
        run_one(0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        run_one(1, 1, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 32'hFFFF_FFFB, 2);
`else
        run_one(0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 35);
        run_one(1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 35);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            req_valid     = 2'($urandom_range(0, 3));
            req_signed    = 2'($urandom_range(0, 3));
            req_dividend0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 500);
            req_dividend1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 500);
            req_divisor0  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 50));
            req_divisor1  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 50));
            rsp_ready     = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (40) @(posedge clock);
        check_output("final_idle", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
